// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage pipelined CPU. A direct-mapped
// branch target buffer (BTB) is looked up combinationally with the IF-stage
// PC. The resolved outcome from the MEM stage trains the BTB and raises a
// same-cycle mispredict/redirect so that the pipeline can flush IF/ID/EX.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous, active-low reset
//   fetch_pc_i         PC of the instruction in IF
//   pred_hit_o         BTB hit for fetch_pc_i (combinational)
//   pred_taken_o       hit and counter MSB set (combinational)
//   pred_target_o      stored target on hit, else fetch_pc_i+4 (combinational)
//   upd_valid_i        a resolved branch is present in MEM this cycle
//   upd_pc_i           PC of the resolved branch
//   upd_taken_i        actual outcome
//   upd_target_i       actual taken target
//   upd_pred_taken_i   direction predicted at IF for this branch
//   upd_pred_target_i  target predicted at IF for this branch
//   mispredict_o       combinational flush request
//   redirect_pc_o      correct next PC for the resolved branch
//   clr_stats_i        synchronous clear of the statistics counters
//   branch_cnt_o       resolved branches counted (saturating)
//   miss_cnt_o         mispredictions counted (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8,
    parameter int CTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       fetch_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [31:0]       pred_target_o,
    input  logic              upd_valid_i,
    input  logic [31:0]       upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [31:0]       upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [31:0]       upd_pred_target_i,
    output logic              mispredict_o,
    output logic [31:0]       redirect_pc_o,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    localparam int ENTRIES = 2 ** IDX_W;

    // Counter landmarks: saturation limit, value given to a fresh allocation
    // (weakly taken) and the value every entry holds out of reset (weakly
    // not taken).
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(2 ** (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(2 ** (CTR_W - 1) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // ------------------------------------------------------------------
    // PC field extraction
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;

    assign fetch_idx = fetch_pc_i[IDX_W+1:2];
    assign fetch_tag = fetch_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx   = upd_pc_i[IDX_W+1:2];
    assign upd_tag   = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Byte-offset bits and PC bits above the tag never take part in the
    // lookup; fold them into a sink so the intent is explicit.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i, upd_pc_i};

    // ------------------------------------------------------------------
    // BTB storage, one register set per entry. Lookup is combinational, so
    // the table lives in flops rather than a registered-read RAM.
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]   tag_arr    [ENTRIES];
    logic [31:0]        target_arr [ENTRIES];
    logic [CTR_W-1:0]   ctr_arr    [ENTRIES];

    // Update-side hit is judged on the current (pre-edge) table contents.
    logic upd_hit;
    assign upd_hit = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             valid_q,  valid_d;
        logic [TAG_W-1:0] tag_q,    tag_d;
        logic [31:0]      target_q, target_d;
        logic [CTR_W-1:0] ctr_q,    ctr_d;
        logic             sel;

        assign sel = upd_valid_i && (upd_idx == IDX_W'(gi));

        always_comb begin
            valid_d  = valid_q;
            tag_d    = tag_q;
            target_d = target_q;
            ctr_d    = ctr_q;
            if (sel) begin
                if (upd_hit) begin
                    if (upd_taken_i) begin
                        ctr_d    = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + CTR_W'(1);
                        target_d = upd_target_i;
                    end else begin
                        ctr_d    = (ctr_q == '0) ? ctr_q : ctr_q - CTR_W'(1);
                    end
                end else if (upd_taken_i) begin
                    // Miss on a taken branch replaces whatever lives here.
                    valid_d  = 1'b1;
                    tag_d    = upd_tag;
                    target_d = upd_target_i;
                    ctr_d    = CTR_WEAK_T;
                end
            end
        end

        // All fields reset together so a reset during a write never leaves
        // a half-written entry.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                valid_q  <= 1'b0;
                tag_q    <= '0;
                target_q <= '0;
                ctr_q    <= CTR_WEAK_NT;
            end else begin
                valid_q  <= valid_d;
                tag_q    <= tag_d;
                target_q <= target_d;
                ctr_q    <= ctr_d;
            end
        end

        assign valid_vec[gi]  = valid_q;
        assign tag_arr[gi]    = tag_q;
        assign target_arr[gi] = target_q;
        assign ctr_arr[gi]    = ctr_q;
    end

    // ------------------------------------------------------------------
    // Fetch-side prediction
    // ------------------------------------------------------------------
    logic fetch_hit;
    assign fetch_hit = valid_vec[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);

    always_comb begin
        pred_hit_o    = fetch_hit;
        pred_taken_o  = fetch_hit && ctr_arr[fetch_idx][CTR_W-1];
        pred_target_o = fetch_hit ? target_arr[fetch_idx] : fetch_pc_i + 32'd4;
    end

    // ------------------------------------------------------------------
    // Resolution: direction mismatch, or both taken with differing targets.
    // Held low while reset is asserted.
    // ------------------------------------------------------------------
    logic dir_wrong;
    logic tgt_wrong;
    logic miss_raw;

    assign dir_wrong = (upd_taken_i != upd_pred_taken_i);
    assign tgt_wrong = upd_taken_i && upd_pred_taken_i && (upd_target_i != upd_pred_target_i);
    assign miss_raw  = upd_valid_i && (dir_wrong || tgt_wrong);

    assign mispredict_o  = rst_i && miss_raw;
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 32'd4;

    // ------------------------------------------------------------------
    // Statistics counters: saturating, clear wins over increment.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (clr_stats_i) begin
            branch_cnt_d = '0;
            miss_cnt_d   = '0;
        end else begin
            if (upd_valid_i && (branch_cnt_q != CNT_MAX)) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
            if (miss_raw && (miss_cnt_q != CNT_MAX)) begin
                miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Drives directed scenarios followed by randomized traffic into
// branch_predictor and compares every output on every falling clock edge
// against a behavioural BTB model kept in plain arrays and integers.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int IDX_W    = 4;
    localparam int TAG_W    = 8;
    localparam int CTR_W    = 2;
    localparam int CNT_W    = 4;
    localparam int ENTRIES  = 1 << IDX_W;
    localparam int CMAX     = (1 << CTR_W) - 1;
    localparam int CWEAK_T  = 1 << (CTR_W - 1);
    localparam int CWEAK_NT = CWEAK_T - 1;
    localparam int SMAX     = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_i;
    logic [31:0]       fetch_pc_i;
    logic              pred_hit_o;
    logic              pred_taken_o;
    logic [31:0]       pred_target_o;
    logic              upd_valid_i;
    logic [31:0]       upd_pc_i;
    logic              upd_taken_i;
    logic [31:0]       upd_target_i;
    logic              upd_pred_taken_i;
    logic [31:0]       upd_pred_target_i;
    logic              mispredict_o;
    logic [31:0]       redirect_pc_o;
    logic              clr_stats_i;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  miss_cnt_o;

    branch_predictor #(
        .IDX_W(IDX_W),
        .TAG_W(TAG_W),
        .CTR_W(CTR_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .fetch_pc_i       (fetch_pc_i),
        .pred_hit_o       (pred_hit_o),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i),
        .mispredict_o     (mispredict_o),
        .redirect_pc_o    (redirect_pc_o),
        .clr_stats_i      (clr_stats_i),
        .branch_cnt_o     (branch_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    bit          m_valid [ENTRIES];
    int          m_tag_a [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_bcnt;
    int          m_mcnt;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_tagf(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag_a[m_idx(pc)] == m_tagf(pc));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= CWEAK_T);
    endfunction

    function automatic logic [31:0] m_ptarget(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    function automatic bit exp_misp();
        if (!rst_i || !upd_valid_i) return 1'b0;
        if (upd_taken_i != upd_pred_taken_i) return 1'b1;
        return upd_taken_i && (upd_target_i != upd_pred_target_i);
    endfunction

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] <= 1'b0;
                m_tag_a[i] <= 0;
                m_tgt[i]   <= '0;
                m_ctr[i]   <= CWEAK_NT;
            end
            m_bcnt <= 0;
            m_mcnt <= 0;
        end else begin
            if (upd_valid_i) begin
                if (m_hit(upd_pc_i)) begin
                    if (upd_taken_i) begin
                        m_ctr[m_idx(upd_pc_i)] <= (m_ctr[m_idx(upd_pc_i)] + 1 > CMAX) ? CMAX : m_ctr[m_idx(upd_pc_i)] + 1;
                        m_tgt[m_idx(upd_pc_i)] <= upd_target_i;
                    end else begin
                        m_ctr[m_idx(upd_pc_i)] <= (m_ctr[m_idx(upd_pc_i)] - 1 < 0) ? 0 : m_ctr[m_idx(upd_pc_i)] - 1;
                    end
                end else if (upd_taken_i) begin
                    m_valid[m_idx(upd_pc_i)] <= 1'b1;
                    m_tag_a[m_idx(upd_pc_i)] <= m_tagf(upd_pc_i);
                    m_tgt[m_idx(upd_pc_i)]   <= upd_target_i;
                    m_ctr[m_idx(upd_pc_i)]   <= CWEAK_T;
                end
            end
            if (clr_stats_i) begin
                m_bcnt <= 0;
                m_mcnt <= 0;
            end else begin
                if (upd_valid_i) m_bcnt <= (m_bcnt < SMAX) ? m_bcnt + 1 : SMAX;
                if (exp_misp())  m_mcnt <= (m_mcnt < SMAX) ? m_mcnt + 1 : SMAX;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("pred_hit",    {31'd0, pred_hit_o},   {31'd0, m_hit(fetch_pc_i)});
            chk("pred_taken",  {31'd0, pred_taken_o}, {31'd0, m_ptaken(fetch_pc_i)});
            chk("pred_target", pred_target_o,         m_ptarget(fetch_pc_i));
            chk("mispredict",  {31'd0, mispredict_o}, {31'd0, exp_misp()});
            if (upd_valid_i && rst_i) begin
                chk("redirect_pc", redirect_pc_o, upd_taken_i ? upd_target_i : upd_pc_i + 32'd4);
            end
            chk("branch_cnt", {28'd0, branch_cnt_o}, m_bcnt);
            chk("miss_cnt",   {28'd0, miss_cnt_o},   m_mcnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_upd(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                             input bit ptk, input logic [31:0] ptg);
        upd_valid_i       = 1'b1;
        upd_pc_i          = pc;
        upd_taken_i       = tk;
        upd_target_i      = tg;
        upd_pred_taken_i  = ptk;
        upd_pred_target_i = ptg;
    endtask

    task automatic idle();
        upd_valid_i = 1'b0;
        clr_stats_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 7))
            0:       return $urandom();
            1:       return 32'hFFFF_FFFC;
            default: return (32'($urandom_range(0, 3)) << (IDX_W + 2)) |
                            (32'($urandom_range(0, ENTRIES - 1)) << 2);
        endcase
    endfunction

    function automatic logic [31:0] rand_tgt();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0180;
            2:       return 32'h0000_0200;
            default: return $urandom() & 32'hFFFF_FFFC;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst_i             = 1'b1;
        fetch_pc_i        = 32'h40;
        upd_valid_i       = 1'b0;
        upd_pc_i          = '0;
        upd_taken_i       = 1'b0;
        upd_target_i      = '0;
        upd_pred_taken_i  = 1'b0;
        upd_pred_target_i = '0;
        clr_stats_i       = 1'b0;
        #2 rst_i = 1'b0;

        // After reset
        @(negedge clk); #1;
        chk("rst_hit",    {31'd0, pred_hit_o},   32'd0);
        chk("rst_taken",  {31'd0, pred_taken_o}, 32'd0);
        chk("rst_target", pred_target_o,         32'h44);
        chk("rst_bcnt",   {28'd0, branch_cnt_o}, 32'd0);
        rst_i  = 1'b1;
        chk_on = 1'b1;

        // Allocation: fetch of the same index this cycle still misses
        next_cycle();
        drive_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #2;
        chk("alloc_misp",  {31'd0, mispredict_o}, 32'd1);
        chk("alloc_redir", redirect_pc_o,         32'h100);
        chk("alloc_same_cycle_hit", {31'd0, pred_hit_o}, 32'd0);
        next_cycle(); idle(); #2;
        chk("alloc_hit",    {31'd0, pred_hit_o},   32'd1);
        chk("alloc_taken",  {31'd0, pred_taken_o}, 32'd1);
        chk("alloc_target", pred_target_o,         32'h100);

        // Two not-taken: ctr 2 -> 0
        repeat (2) begin
            next_cycle(); drive_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        next_cycle(); idle(); #2;
        chk("nt_hit",    {31'd0, pred_hit_o},   32'd1);
        chk("nt_taken",  {31'd0, pred_taken_o}, 32'd0);
        chk("nt_target", pred_target_o,         32'h100);

        // Four taken: ctr 0 -> 3, saturates
        repeat (4) begin
            next_cycle(); drive_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
        end
        next_cycle(); idle(); #2;
        chk("sat_taken3", {31'd0, pred_taken_o}, 32'd1);
        next_cycle(); drive_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle(); idle(); #2;
        chk("sat_taken2", {31'd0, pred_taken_o}, 32'd1);
        next_cycle(); drive_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        next_cycle(); idle(); #2;
        chk("sat_taken1", {31'd0, pred_taken_o}, 32'd0);

        // Target mispredict
        next_cycle(); drive_upd(32'h40, 1'b1, 32'h180, 1'b1, 32'h100); #2;
        chk("tgt_misp",  {31'd0, mispredict_o}, 32'd1);
        chk("tgt_redir", redirect_pc_o,         32'h180);
        next_cycle(); idle(); #2;
        chk("tgt_updated", pred_target_o,         32'h180);
        chk("tgt_misscnt", {28'd0, miss_cnt_o},   32'd2);
        chk("tgt_brcnt",   {28'd0, branch_cnt_o}, 32'd10);

        // Tag aliasing: 0x80 shares index 0 with 0x40
        next_cycle(); drive_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
        next_cycle(); idle(); #2;
        chk("alias_old_hit", {31'd0, pred_hit_o}, 32'd0);
        fetch_pc_i = 32'h80; #1;
        chk("alias_new_hit",    {31'd0, pred_hit_o}, 32'd1);
        chk("alias_new_target", pred_target_o,       32'h200);

        // Statistics saturation at 15
        repeat (20) begin
            next_cycle(); drive_upd(32'h1000, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        next_cycle(); idle(); #2;
        chk("stat_sat_br",   {28'd0, branch_cnt_o}, 32'd15);
        chk("stat_sat_miss", {28'd0, miss_cnt_o},   32'd3);

        // Clear wins over a simultaneous counted mispredict
        next_cycle(); drive_upd(32'h2000, 1'b1, 32'h300, 1'b0, 32'h2004); clr_stats_i = 1'b1;
        next_cycle(); idle(); #2;
        chk("clr_br",   {28'd0, branch_cnt_o}, 32'd0);
        chk("clr_miss", {28'd0, miss_cnt_o},   32'd0);

        // PC wrap
        fetch_pc_i = 32'hFFFF_FFFC;
        next_cycle(); drive_upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40); #2;
        chk("wrap_pred_target", pred_target_o,         32'h0);
        chk("wrap_misp",        {31'd0, mispredict_o}, 32'd1);
        chk("wrap_redir",       redirect_pc_o,         32'h0);

        // Asynchronous reset pulse in the middle of an update
        next_cycle(); idle(); fetch_pc_i = 32'h2000; #1;
        chk("pre_rst_hit", {31'd0, pred_hit_o}, 32'd1);
        drive_upd(32'h40, 1'b1, 32'h500, 1'b0, 32'h0); #1;
        chk("pre_rst_misp", {31'd0, mispredict_o}, 32'd1);
        rst_i = 1'b0; #1;
        chk("rst_pulse_hit",  {31'd0, pred_hit_o},   32'd0);
        chk("rst_pulse_misp", {31'd0, mispredict_o}, 32'd0);
        chk("rst_pulse_br",   {28'd0, branch_cnt_o}, 32'd0);
        @(negedge clk); #2 rst_i = 1'b1;
        next_cycle(); idle();

        // Randomized traffic
        repeat (3000) begin
            next_cycle();
            fetch_pc_i   = rand_pc();
            upd_valid_i  = ($urandom_range(0, 3) != 0);
            upd_pc_i     = rand_pc();
            upd_taken_i  = 1'($urandom_range(0, 1));
            upd_target_i = rand_tgt();
            if ($urandom_range(0, 1) == 1) begin
                upd_pred_taken_i  = m_ptaken(upd_pc_i);
                upd_pred_target_i = m_ptarget(upd_pc_i);
            end else begin
                upd_pred_taken_i  = 1'($urandom_range(0, 1));
                upd_pred_target_i = ($urandom_range(0, 1) == 1) ? upd_target_i : rand_tgt();
            end
            clr_stats_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_i = 1'b0;
                @(negedge clk); #2 rst_i = 1'b1;
            end
        end

        next_cycle(); idle();
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
